// File: rtl/crc_pkg.sv
// Shared CRC-8 constants, state encoding and the single-bit LFSR step
// used by the serial CRC generator.
package crc_pkg;

   localparam int                   CRC_WIDTH = 8;
   localparam int                   CNT_W     = $clog2(CRC_WIDTH);
   localparam logic [CRC_WIDTH-1:0] CRC_SEED  = 8'hD8;
   localparam logic [CRC_WIDTH-1:0] CRC_TAPS  = 8'h44;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      OUT  = 2'd2
   } state_t;

   // Galois step: the new top bit is the feedback, and tapped bits pick it up on the way down.
   function automatic logic [CRC_WIDTH-1:0] lfsr_step(input logic [CRC_WIDTH-1:0] l,
                                                      input logic                 d);
      logic                 fb;
      logic [CRC_WIDTH-1:0] n;
      fb             = d ^ l[0];
      n[CRC_WIDTH-1] = fb;
      for (int i = 1; i < CRC_WIDTH; i++) begin
         n[i-1] = CRC_TAPS[i] ? (l[i] ^ fb) : l[i];
      end
      return n;
   endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8: absorbs LSB-first message bits while ACTIVE is high, then
// streams the CRC LSB-first on CRC with Valid high for CRC_WIDTH cycles.
module crc8_serial
   import crc_pkg::*;
(
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 ACTIVE,
   input  logic                 DATA,
   output logic                 CRC,
   output logic                 Valid,
   output state_t               o_dbg_state,
   output logic [CRC_WIDTH-1:0] o_dbg_lfsr
);

   state_t               r_state;
   logic [CRC_WIDTH-1:0] r_lfsr;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_crc;
   logic                 r_valid;

   state_t               w_state_next;
   logic [CRC_WIDTH-1:0] w_lfsr_next;
   logic [CNT_W-1:0]     w_cnt_next;
   logic                 w_crc_next;
   logic                 w_valid_next;

   // Message bits win from any state; a shift-out in progress is abandoned.
   always_comb begin
      w_state_next = r_state;
      if (ACTIVE) begin
         w_state_next = CALC;
      end else begin
         case (r_state)
            CALC:    w_state_next = OUT;
            OUT:     if (r_cnt == '0) w_state_next = IDLE;
            default: w_state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      w_lfsr_next  = r_lfsr;
      w_cnt_next   = r_cnt;
      w_crc_next   = r_crc;
      w_valid_next = r_valid;
      if (ACTIVE) begin
         w_lfsr_next  = lfsr_step((r_state == OUT) ? CRC_SEED : r_lfsr, DATA);
         w_cnt_next   = '0;
         w_crc_next   = 1'b0;
         w_valid_next = 1'b0;
      end else begin
         case (r_state)
            CALC: begin
               w_crc_next   = r_lfsr[0];
               w_lfsr_next  = r_lfsr >> 1;
               w_valid_next = 1'b1;
               w_cnt_next   = CNT_W'(1);
            end
            OUT: begin
               // Counter wraps to zero once the last bit has been emitted.
               if (r_cnt == '0) begin
                  w_crc_next   = 1'b0;
                  w_valid_next = 1'b0;
                  w_lfsr_next  = CRC_SEED;
                  w_cnt_next   = '0;
               end else begin
                  w_crc_next   = r_lfsr[0];
                  w_lfsr_next  = r_lfsr >> 1;
                  w_valid_next = 1'b1;
                  w_cnt_next   = r_cnt + CNT_W'(1);
               end
            end
            default: begin
               w_crc_next   = 1'b0;
               w_valid_next = 1'b0;
               w_lfsr_next  = CRC_SEED;
               w_cnt_next   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= IDLE;
         r_lfsr  <= CRC_SEED;
         r_cnt   <= '0;
         r_crc   <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_lfsr  <= w_lfsr_next;
         r_cnt   <= w_cnt_next;
         r_crc   <= w_crc_next;
         r_valid <= w_valid_next;
      end
   end

   assign CRC         = r_crc;
   assign Valid       = r_valid;
   assign o_dbg_state = r_state;
   assign o_dbg_lfsr  = r_lfsr;

endmodule

// File: tb/tb_crc8_serial.sv
// Directed bench for crc8_serial: vector table of messages with expected CRCs
// plus hand-written reset, abort and idle sequences.
module tb_crc8_serial;
   import crc_pkg::*;

   logic       CLK;
   logic       RST;
   logic       ACTIVE;
   logic       DATA;
   logic       CRC;
   logic       Valid;
   state_t     dbg_state;
   logic [7:0] dbg_lfsr;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [7:0] msg;
      int         len;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[13];

   crc8_serial dut (
      .CLK        (CLK),
      .RST        (RST),
      .ACTIVE     (ACTIVE),
      .DATA       (DATA),
      .CRC        (CRC),
      .Valid      (Valid),
      .o_dbg_state(dbg_state),
      .o_dbg_lfsr (dbg_lfsr)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference: with taps 0x44 the Galois step folds to (L>>1) ^ (fb ? 0xA2 : 0).
   function automatic logic [7:0] model_crc(input logic [7:0] msg, input int len);
      logic [7:0] l;
      logic       fb;
      l = 8'hD8;
      for (int i = 0; i < len; i++) begin
         fb = msg[i] ^ l[0];
         l  = (l >> 1) ^ (fb ? 8'hA2 : 8'h00);
      end
      return l;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_bits(input logic [7:0] msg, input int len);
      for (int i = 0; i < len; i++) begin
         @(negedge CLK);
         ACTIVE = 1'b1;
         DATA   = msg[i];
      end
   endtask

   task automatic run_msg(input logic [7:0] msg, input int len, input logic [7:0] exp,
                          input string name);
      logic [7:0] got;
      int         bad_valid;
      send_bits(msg, len);
      @(negedge CLK);
      ACTIVE    = 1'b0;
      DATA      = 1'($urandom_range(0, 1));
      got       = '0;
      bad_valid = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge CLK);
         #1;
         if (Valid !== 1'b1) bad_valid++;
         got[i] = CRC;
      end
      chk({name, " crc"}, 32'(got), 32'(exp));
      chk({name, " valid_run_gaps"}, 32'(bad_valid), 32'd0);
      @(posedge CLK);
      #1;
      chk({name, " valid_drop"}, {30'd0, Valid, CRC}, 32'd0);
      chk({name, " reseed"}, 32'(dbg_lfsr), 32'hD8);
      chk({name, " back_idle"}, 32'(dbg_state), 32'(IDLE));
   endtask

   initial begin
      logic [3:0] part;
      int         bad_idle;

      vecs[0]  = '{msg: 8'h00, len: 8, exp: 8'h36};
      vecs[1]  = '{msg: 8'hFF, len: 8, exp: 8'hFA};
      vecs[2]  = '{msg: 8'h01, len: 8, exp: 8'h26};
      vecs[3]  = '{msg: 8'h01, len: 1, exp: 8'hCE};
      vecs[4]  = '{msg: 8'hA5, len: 8, exp: model_crc(8'hA5, 8)};
      vecs[5]  = '{msg: 8'h3C, len: 8, exp: model_crc(8'h3C, 8)};
      vecs[6]  = '{msg: 8'h5A, len: 8, exp: model_crc(8'h5A, 8)};
      vecs[7]  = '{msg: 8'h80, len: 8, exp: model_crc(8'h80, 8)};
      vecs[8]  = '{msg: 8'h7E, len: 8, exp: model_crc(8'h7E, 8)};
      vecs[9]  = '{msg: 8'hC3, len: 8, exp: model_crc(8'hC3, 8)};
      vecs[10] = '{msg: 8'h12, len: 8, exp: model_crc(8'h12, 8)};
      vecs[11] = '{msg: 8'hEF, len: 8, exp: model_crc(8'hEF, 8)};
      vecs[12] = '{msg: 8'h99, len: 8, exp: model_crc(8'h99, 8)};

      RST    = 1'b0;
      ACTIVE = 1'b0;
      DATA   = 1'b0;
      #12;
      chk("reset outputs", {30'd0, Valid, CRC}, 32'd0);
      @(negedge CLK);
      RST = 1'b1;
      #1;
      chk("reset lfsr", 32'(dbg_lfsr), 32'hD8);
      chk("reset state", 32'(dbg_state), 32'(IDLE));

      // Idle with ACTIVE low must stay silent.
      bad_idle = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         DATA = 1'($urandom_range(0, 1));
         @(posedge CLK);
         #1;
         if (Valid !== 1'b0 || CRC !== 1'b0) bad_idle++;
      end
      chk("idle silent cycles", 32'(bad_idle), 32'd0);
      chk("idle lfsr", 32'(dbg_lfsr), 32'hD8);

      // Back-to-back messages, no reset in between.
      for (int v = 0; v < 13; v++) begin
         run_msg(vecs[v].msg, vecs[v].len, vecs[v].exp, $sformatf("vec%0d", v));
      end

      // Abort the shift-out after bit 3 has been shown.
      send_bits(8'h00, 8);
      @(negedge CLK);
      ACTIVE = 1'b0;
      part   = '0;
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK);
         #1;
         part[i] = CRC;
      end
      chk("abort first bits", 32'(part), 32'h6);
      chk("abort valid before", 32'(Valid), 32'd1);
      @(negedge CLK);
      ACTIVE = 1'b1;
      DATA   = 1'b0;
      @(posedge CLK);
      #1;
      chk("abort valid drop", 32'(Valid), 32'd0);
      chk("abort reseed absorb", 32'(dbg_lfsr), 32'h6C);
      chk("abort state", 32'(dbg_state), 32'(CALC));
      run_msg(8'h00, 7, 8'h36, "after_abort");

      // Asynchronous reset between edges during shift-out.
      send_bits(8'h00, 8);
      @(negedge CLK);
      ACTIVE = 1'b0;
      @(posedge CLK);
      @(posedge CLK);
      #1;
      chk("pre-reset bit1", {30'd0, Valid, CRC}, 32'h3);
      #2;
      RST = 1'b0;
      #1;
      chk("async reset outputs", {30'd0, Valid, CRC}, 32'd0);
      chk("async reset lfsr", 32'(dbg_lfsr), 32'hD8);
      @(negedge CLK);
      RST = 1'b1;
      run_msg(8'h00, 8, 8'h36, "after_async_rst");

      // Reset mid-message after four bits.
      send_bits(8'hFF, 4);
      @(negedge CLK);
      ACTIVE = 1'b0;
      RST    = 1'b0;
      #1;
      chk("midmsg reset state", 32'(dbg_state), 32'(IDLE));
      chk("midmsg reset lfsr", 32'(dbg_lfsr), 32'hD8);
      @(negedge CLK);
      RST = 1'b1;
      run_msg(8'h00, 8, 8'h36, "after_midmsg_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
